// File: rtl/uart_program_loader_pkg.sv
// rtl/uart_program_loader_pkg.sv - shared types and helpers for the UART program loader
// Purpose: state encodings for the receive and word-packing FSMs, byte width and a
//          counter-width helper. Optional parity state depends on UART_LOADER_PARITY_EN.
// Ports: none (package).
package loader_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_LOADER_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        W_HI,
        W_LO
    } word_state_t;

    // Width needed for a counter that runs 0 .. max_count-1.
    function automatic int counter_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - program RAM write port bundle
// Purpose: groups the write strobe, instruction word and address that drive the text RAM.
// Ports: program_write (strobe), program_cmd (word), write_address (target address).
//        master = loader side, slave = RAM side.
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
);
    logic                  program_write;
    logic [DATA_WIDTH-1:0] program_cmd;
    logic [ADDR_WIDTH-1:0] write_address;

    modport master (output program_write, output program_cmd, output write_address);
    modport slave  (input  program_write, input  program_cmd, input  write_address);
endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// rtl/uart_program_loader_uart_rx.sv - UART byte receiver (synchronizer, bit timer, rx FSM)
// Purpose: receives 8N1 frames (8E1 when UART_LOADER_PARITY_EN is defined), LSB first.
// Ports: clk, reset (sync active-high), rx (async line, idle high),
//        byte_data/byte_valid (received byte + 1-cycle pulse), frame_error (bad stop pulse),
//        busy (frame in progress), parity_error (bad parity pulse, macro builds only).
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_valid,
    output logic                  frame_error,
    output logic                  busy
`ifdef UART_LOADER_PARITY_EN
    ,
    output logic                  parity_error
`endif
);
    localparam int CW = counter_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    rx_state_t             state;
    logic [CW-1:0]         clk_cnt;
    logic [2:0]            bit_idx;
    logic [BYTE_WIDTH-1:0] shift;
`ifdef UART_LOADER_PARITY_EN
    logic                  parity_bad;
`endif

    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            parity_error <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    // Edge (not level) start detection: after a bad stop bit the
                    // line may still be low and must not trigger a phantom frame.
                    if (!rx_sync && rx_prev) state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[BYTE_WIDTH-1:1]};
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_LOADER_PARITY_EN
                        if (bit_idx == 3'd7) state <= RX_PARITY;
`else
                        if (bit_idx == 3'd7) state <= RX_STOP;
`endif
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef UART_LOADER_PARITY_EN
                RX_PARITY: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt    <= '0;
                        parity_bad <= (^shift) ^ rx_sync;
                        state      <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        state   <= RX_IDLE;
                        if (!rx_sync) begin
                            frame_error <= 1'b1;
`ifdef UART_LOADER_PARITY_EN
                        end else if (parity_bad) begin
                            parity_error <= 1'b1;
`endif
                        end else begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART front end that writes instruction words into program RAM
// Purpose: packs received byte pairs (high byte first) into DATA_WIDTH-bit words, issues one
//          write strobe per word with an auto-incrementing address, and ends an upload after
//          TIMEOUT_BITS idle bit periods. UART_LOADER_PARITY_EN selects 8E1 framing.
// Ports: clk, reset (sync active-high), rx (UART line),
//        prog (master: program_write, program_cmd, write_address),
//        loading (upload in progress), done (end-of-upload pulse),
//        frame_error (bad stop pulse), parity_error (bad parity pulse, macro builds only).
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 12,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    uart_program_loader_if.master  prog,
    output logic                   loading,
    output logic                   done,
    output logic                   frame_error
`ifdef UART_LOADER_PARITY_EN
    ,
    output logic                   parity_error
`endif
);
    localparam int HI_WIDTH = DATA_WIDTH - BYTE_WIDTH;
    localparam int BIT_CW   = counter_width(CLKS_PER_BIT);
    localparam int IDLE_CW  = counter_width(TIMEOUT_BITS);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_CW-1:0] IDLE_LAST = IDLE_CW'(TIMEOUT_BITS - 1);

    logic [BYTE_WIDTH-1:0] byte_data;
    logic                  byte_valid;
    logic                  rx_busy;
    logic                  rx_bad;
    word_state_t           wstate;
    logic [HI_WIDTH-1:0]   hi_bits;
    logic [BIT_CW-1:0]     bit_cnt;
    logic [IDLE_CW-1:0]    idle_cnt;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .frame_error  (frame_error),
        .busy         (rx_busy)
`ifdef UART_LOADER_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

`ifdef UART_LOADER_PARITY_EN
    assign rx_bad = frame_error | parity_error;
`else
    assign rx_bad = frame_error;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prog.program_write <= 1'b0;
            prog.program_cmd   <= '0;
            prog.write_address <= '0;
            loading            <= 1'b0;
            done               <= 1'b0;
            wstate             <= W_HI;
            hi_bits            <= '0;
            bit_cnt            <= '0;
            idle_cnt           <= '0;
        end else begin
            prog.program_write <= 1'b0;
            done               <= 1'b0;

            // Address advances the cycle after the strobe so it is stable during it.
            if (prog.program_write) prog.write_address <= prog.write_address + 1'b1;

            if (byte_valid) begin
                loading <= 1'b1;
                if (wstate == W_HI) begin
                    hi_bits <= byte_data[HI_WIDTH-1:0];
                    wstate  <= W_LO;
                end else begin
                    prog.program_cmd   <= {hi_bits, byte_data};
                    prog.program_write <= 1'b1;
                    wstate             <= W_HI;
                end
            end else if (rx_bad) begin
                // Drop any held high byte so the next good byte starts a fresh word.
                wstate <= W_HI;
            end

            // Idle timer only runs between frames of an active upload; any frame
            // activity (start edge onward) clears it, so it never fires with byte_valid.
            if (rx_busy || !loading) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt           <= '0;
                    loading            <= 1'b0;
                    done               <= 1'b1;
                    wstate             <= W_HI;
                    prog.write_address <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - self-checking bench for uart_program_loader
module tb_uart_program_loader;
    localparam int CPB = 4;
    localparam int TB  = 8;
    localparam int AW  = 8;
    localparam int DW  = 12;

    logic clk;
    logic reset;
    logic rx;
    logic loading;
    logic done;
    logic frame_error;
`ifdef UART_LOADER_PARITY_EN
    logic parity_error;
`endif

    uart_program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) prog ();

    uart_program_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TIMEOUT_BITS (TB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .prog         (prog),
        .loading      (loading),
        .done         (done),
        .frame_error  (frame_error)
`ifdef UART_LOADER_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed traffic, captured on the falling edge.
    logic [AW+DW-1:0] obs_q[$];
    int obs_done = 0;
    int obs_ferr = 0;
    int obs_perr = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (prog.program_write) obs_q.push_back({prog.write_address, prog.program_cmd});
            if (done) obs_done++;
            if (frame_error) obs_ferr++;
`ifdef UART_LOADER_PARITY_EN
            if (parity_error) obs_perr++;
`endif
        end
    end

    // Reference model: an upload is a stream of good bytes taken in pairs.
    logic [AW+DW-1:0] exp_q[$];
    int m_addr = 0;
    logic [DW-9:0] m_hi;
    bit m_hi_pending = 0;
    bit m_loading = 0;
    int exp_done = 0;
    int exp_ferr = 0;
    int exp_perr = 0;

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_hi_pending = 0;
        end else begin
            m_loading = 1;
            if (!m_hi_pending) begin
                m_hi = b[DW-9:0];
                m_hi_pending = 1;
            end else begin
                exp_q.push_back({AW'(m_addr), m_hi, b});
                m_addr = (m_addr + 1) % (1 << AW);
                m_hi_pending = 0;
            end
        end
    endfunction

    function automatic void model_reset();
        m_addr = 0;
        m_hi_pending = 0;
        m_loading = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        tick(n * CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit par_flip);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_LOADER_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        if (!stop_bit) exp_ferr++;
        else if (par_flip) exp_perr++;
        model_byte(b, stop_bit && !par_flip);
    endtask

    task automatic wait_timeout();
        idle_bits(TB + 4);
        if (m_loading) begin
            exp_done++;
            model_reset();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (prog.program_write !== 1'b0 || prog.program_cmd !== '0 || prog.write_address !== '0) begin
            errors++;
            $display("FAIL reset_port: write=%b cmd=%h addr=%h, required all 0",
                     prog.program_write, prog.program_cmd, prog.write_address);
        end
        checks++;
        if (loading !== 1'b0 || done !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: loading=%b done=%b ferr=%b, required 0",
                     loading, done, frame_error);
        end
    endtask

    task automatic test_basic();
        logic [AW+DW-1:0] w0, w1;
        w0 = {8'd0, 12'hABC};
        w1 = {8'd1, 12'h123};
        send_frame(8'h0A, 1'b1, 0);
        send_frame(8'hBC, 1'b1, 0);
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h23, 1'b1, 0);
        tick(3);
        checks++;
        if (loading !== 1'b1) begin
            errors++;
            $display("FAIL basic_loading: got %b, required 1", loading);
        end
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d strobes, required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== w0 || obs_q[1] !== w1) begin
                errors++;
                $display("FAIL basic_words: got %h %h, required %h %h", obs_q[0], obs_q[1], w0, w1);
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_model[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        wait_timeout();
        checks++;
        if (obs_done != exp_done || loading !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%0d loading=%b, required done=%0d loading=0",
                     obs_done, loading, exp_done);
        end
    endtask

    task automatic test_glitch();
        int ferr0;
        ferr0 = obs_ferr;
        rx = 1'b0;
        tick(1);
        idle_bits(4);
        checks++;
        if (loading !== 1'b0 || obs_q.size() != 0 || obs_ferr != ferr0) begin
            errors++;
            $display("FAIL glitch: loading=%b strobes=%0d ferr=%0d, required 0 0 %0d",
                     loading, obs_q.size(), obs_ferr, ferr0);
        end
        obs_q.delete();
    endtask

    task automatic test_frame_error();
        send_frame(8'h0A, 1'b1, 0);
        send_frame(8'hBC, 1'b0, 0);
        idle_bits(1);
        send_frame(8'h0F, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        tick(3);
        checks++;
        if (obs_ferr != exp_ferr) begin
            errors++;
            $display("FAIL ferr_count: got %0d, required %0d", obs_ferr, exp_ferr);
        end
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL ferr_strobes: got %0d, required 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL ferr_word: got %h, required %h", obs_q[0], exp_q[0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        wait_timeout();
    endtask

    task automatic test_wrap();
        int ferr0;
        ferr0 = obs_ferr;
        for (int i = 0; i < 257; i++) begin
            send_frame(8'($urandom), 1'b1, 0);
            send_frame(8'($urandom), 1'b1, 0);
        end
        tick(3);
        checks++;
        if (obs_q.size() != 257) begin
            errors++;
            $display("FAIL wrap_count: got %0d, required 257", obs_q.size());
        end else begin
            checks++;
            if (obs_q[256][AW+DW-1:DW] !== '0) begin
                errors++;
                $display("FAIL wrap_addr: got %h, required 0", obs_q[256][AW+DW-1:DW]);
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_ferr != ferr0) begin
            errors++;
            $display("FAIL wrap_ferr: got %0d, required %0d", obs_ferr, ferr0);
        end
        obs_q.delete();
        exp_q.delete();
        wait_timeout();
    endtask

    task automatic test_timeout();
        int done0;
        done0 = obs_done;
        send_frame(8'h05, 1'b1, 0);
        wait_timeout();
        checks++;
        if (obs_done != done0 + 1 || loading !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: done=%0d loading=%b strobes=%0d, required %0d 0 0",
                     obs_done - done0, loading, obs_q.size(), 1);
        end
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h23, 1'b1, 0);
        tick(3);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_next_count: got %0d, required 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL timeout_next_word: got %h, required %h", obs_q[0], exp_q[0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        wait_timeout();
    endtask

    task automatic test_random();
        bit last_bad;
        last_bad = 0;
        for (int i = 0; i < 60; i++) begin
            logic stop_bit;
            int gap;
            stop_bit = ($urandom_range(0, 9) != 0);
            gap = $urandom_range(0, 3);
            if (last_bad && gap == 0) gap = 1;
            if (gap > 0) idle_bits(gap);
            if ($urandom_range(0, 14) == 0) wait_timeout();
            send_frame(8'($urandom), stop_bit, 0);
            last_bad = !stop_bit;
        end
        idle_bits(1);
        wait_timeout();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_done != exp_done || obs_ferr != exp_ferr) begin
            errors++;
            $display("FAIL random_events: done=%0d ferr=%0d, required %0d %0d",
                     obs_done, obs_ferr, exp_done, exp_ferr);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_parity();
        send_frame(8'h0A, 1'b1, 1);
        send_frame(8'hBC, 1'b1, 0);
        tick(3);
        checks++;
        if (obs_perr != exp_perr || obs_q.size() != 0) begin
            errors++;
            $display("FAIL parity: perr=%0d strobes=%0d, required %0d 0",
                     obs_perr, obs_q.size(), exp_perr);
        end
        obs_q.delete();
        exp_q.delete();
        wait_timeout();
    endtask

    task automatic test_reset_mid_byte();
        send_frame(8'h12, 1'b1, 0);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
        reset = 1'b1;
        tick(1);
        checks++;
        if (prog.program_write !== 1'b0 || prog.write_address !== '0 || loading !== 1'b0 ||
            done !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset: write=%b addr=%h loading=%b done=%b ferr=%b, required 0",
                     prog.program_write, prog.write_address, loading, done, frame_error);
        end
        reset = 1'b0;
        model_reset();
        idle_bits(2);
        send_frame(8'h03, 1'b1, 0);
        send_frame(8'h45, 1'b1, 0);
        tick(3);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_count: got %0d, required 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL midreset_word: got %h, required %h", obs_q[0], exp_q[0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        wait_timeout();
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        tick(3);
        test_reset();
        reset = 1'b0;
        tick(2);
        test_basic();
        test_glitch();
        test_frame_error();
        test_wrap();
        test_timeout();
        test_random();
`ifdef UART_LOADER_PARITY_EN
        test_parity();
`endif
        test_reset_mid_byte();
        checks++;
        if (obs_done != exp_done) begin
            errors++;
            $display("FAIL done_total: got %0d, required %0d", obs_done, exp_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
